// File: rtl/subkey_sched_pkg.sv
// Shared types, widths and LFSR step for the subkey scheduler.
// Holds the FSM state enum, key/seed widths and the seed-advance function.
package subkey_sched_pkg;

  localparam int KEY_W  = 80;
  localparam int SEED_W = 12;

  // x^12+x^6+x^4+x+1 -> feedback from s[11], s[5], s[3], s[0]
  localparam logic [SEED_W-1:0] LFSR_TAPS     = 12'h829;
  localparam logic [SEED_W-1:0] SEED_ZERO_SUB = 12'hACE;

  typedef enum logic [2:0] {
    IDLE,
    GEN_RST,
    RUN,
    PRESENT,
    FINISH
  } sched_state_t;

  function automatic logic [SEED_W-1:0] lfsr_next(
    input logic [SEED_W-1:0] s
  );
    return {s[SEED_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/seed_lfsr.sv
// Seed register: loads a round-0 seed (zero replaced) and steps the LFSR.
// Ports: clk, rst_n, load+seed, step, value (current seed).
module seed_lfsr
  import subkey_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [SEED_W-1:0] seed,
  output logic [SEED_W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      // an all-zero seed would lock the LFSR
      value <= (seed == '0) ? SEED_ZERO_SUB : seed;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/subkey_scheduler.sv
// Chains subkeyGenerator runs into num_rounds round keys with timeout.
// Ports: start/abort/config in, gen_* to/from generator, key_* handshake out.
module subkey_scheduler
  import subkey_sched_pkg::*;
#(
  parameter int RND_W   = 5,
  parameter int TIMEOUT = 4095
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [RND_W-1:0]  num_rounds,
  input  logic [KEY_W-1:0]  master_key,
  input  logic [SEED_W-1:0] master_seed,
  output logic              gen_reset,
  output logic              gen_run,
  output logic [SEED_W-1:0] gen_seed,
  output logic [KEY_W-1:0]  gen_init_key,
  input  logic              gen_done,
  input  logic [KEY_W-1:0]  gen_subkey,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [KEY_W-1:0]  key_data,
  output logic [RND_W-1:0]  key_index,
  output logic              busy,
  output logic              seq_done,
  output logic              timeout_err
);

  localparam logic [11:0] TMO_LAST = 12'(TIMEOUT - 1);

  sched_state_t     state;
  logic [RND_W-1:0] rounds;
  logic [RND_W-1:0] round_cnt;
  logic [11:0]      tmo_cnt;
  logic             go;
  logic             last_round;
  logic             accept;
  logic             seed_load;
  logic             seed_step;

  assign go         = start && (num_rounds != '0);
  assign last_round = (round_cnt == rounds - RND_W'(1));
  assign accept     = (state == PRESENT) && key_ready;
  assign seed_load  = !abort && (state == IDLE) && go;
  assign seed_step  = !abort && accept && !last_round;

  assign gen_reset = (state == IDLE) || (state == GEN_RST);
  assign gen_run   = (state == RUN);
  assign key_valid = (state == PRESENT);
  assign busy      = (state != IDLE);

  seed_lfsr u_lfsr (
    .clk   (Clk),
    .rst_n (Reset_n),
    .load  (seed_load),
    .step  (seed_step),
    .seed  (master_seed),
    .value (gen_seed)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      rounds       <= '0;
      round_cnt    <= '0;
      tmo_cnt      <= '0;
      gen_init_key <= '0;
      key_data     <= '0;
      key_index    <= '0;
      seq_done     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (go) begin
              rounds       <= num_rounds;
              gen_init_key <= master_key;
              round_cnt    <= '0;
              timeout_err  <= 1'b0;
              state        <= GEN_RST;
            end
          end
          GEN_RST: begin
            tmo_cnt <= '0;
            state   <= RUN;
          end
          RUN: begin
            if (gen_done) begin
              key_data  <= gen_subkey;
              key_index <= round_cnt;
              state     <= PRESENT;
            end else if (tmo_cnt == TMO_LAST) begin
              timeout_err <= 1'b1;
              state       <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 12'd1;
            end
          end
          PRESENT: begin
            if (key_ready) begin
              if (last_round) begin
                state <= FINISH;
              end else begin
                round_cnt    <= round_cnt + RND_W'(1);
                gen_init_key <= key_data;
                state        <= GEN_RST;
              end
            end
          end
          FINISH: begin
            seq_done <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_subkey_scheduler.sv
// Directed bench for subkey_scheduler with a latency-configurable
// generator model (subkey = init_key + 1).
module tb_subkey_scheduler;
  import subkey_sched_pkg::*;

  localparam logic [79:0] K  = 80'h0123_4567_89AB_CDEF_0011;
  localparam logic [79:0] K2 = 80'hFEDC_0000_1111_2222_3333;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        start;
  logic        abort;
  logic [4:0]  num_rounds;
  logic [79:0] master_key;
  logic [11:0] master_seed;
  logic        gen_reset;
  logic        gen_run;
  logic [11:0] gen_seed;
  logic [79:0] gen_init_key;
  logic        gen_done = 1'b0;
  logic [79:0] gen_subkey = '0;
  logic        key_valid;
  logic        key_ready;
  logic [79:0] key_data;
  logic [4:0]  key_index;
  logic        busy;
  logic        seq_done;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int both_cnt = 0;
  int rst_cyc  = 0;
  int done_cnt = 0;
  int m_lat = 10;
  int m_cnt = 0;
  bit m_hang = 1'b0;

  logic [11:0] seeds [4] = '{12'h5A3, 12'hB46, 12'h68D, 12'hD1A};

  subkey_scheduler dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .abort        (abort),
    .num_rounds   (num_rounds),
    .master_key   (master_key),
    .master_seed  (master_seed),
    .gen_reset    (gen_reset),
    .gen_run      (gen_run),
    .gen_seed     (gen_seed),
    .gen_init_key (gen_init_key),
    .gen_done     (gen_done),
    .gen_subkey   (gen_subkey),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_data     (key_data),
    .key_index    (key_index),
    .busy         (busy),
    .seq_done     (seq_done),
    .timeout_err  (timeout_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (gen_reset) begin
      m_cnt    <= 0;
      gen_done <= 1'b0;
    end else if (gen_run && !gen_done && !m_hang) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == m_lat - 1) begin
        gen_done   <= 1'b1;
        gen_subkey <= gen_init_key + 80'd1;
      end
    end
  end

  always begin
    @(negedge Clk);
    #1;
    if (gen_run && gen_reset) both_cnt++;
    if (busy && gen_reset) rst_cyc++;
    if (seq_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [79:0] got,
                     input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [4:0] n, input logic [79:0] k,
                          input logic [11:0] s);
    num_rounds  = n;
    master_key  = k;
    master_seed = s;
    start       = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int t = 0;
    while (gen_run !== 1'b1 && t < 200) begin @(negedge Clk); t++; end
    chk(tag, 80'(t < 200), 80'd1);
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    while (key_valid !== 1'b1 && t < 200) begin @(negedge Clk); t++; end
    chk(tag, 80'(t < 200), 80'd1);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (seq_done !== 1'b1 && t < 400) begin @(negedge Clk); t++; end
    chk(tag, 80'(t < 400), 80'd1);
  endtask

  initial begin
    logic [79:0] held;
    int r0, d0, runs, t;
    Reset_n = 1'b1; start = 1'b0; abort = 1'b0; key_ready = 1'b1;
    num_rounds = '0; master_key = '0; master_seed = '0;
    #1 Reset_n = 1'b0;
    #12;
    chk("rst_gen_reset", gen_reset, 1);
    chk("rst_gen_run", gen_run, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_key_data", key_data, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // 1: single round, latency checks, start while busy ignored
    do_start(5'd1, K, 12'h5A3);
    chk("t1_c1_run", gen_run, 0);
    chk("t1_c1_reset", gen_reset, 1);
    chk("t1_c1_busy", busy, 1);
    @(negedge Clk);
    chk("t1_c2_run", gen_run, 1);
    chk("t1_c2_reset", gen_reset, 0);
    chk("t1_seed", gen_seed, 12'h5A3);
    chk("t1_init", gen_init_key, K);
    num_rounds = 5'd3; master_key = ~K; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    wait_valid("t1_valid_to");
    chk("t1_data_gen", key_data, gen_subkey);
    chk("t1_data", key_data, K + 80'd1);
    chk("t1_index", key_index, 0);
    @(negedge Clk);
    chk("t1_fin_done", seq_done, 0);
    chk("t1_fin_valid", key_valid, 0);
    chk("t1_fin_busy", busy, 1);
    @(negedge Clk);
    chk("t1_done", seq_done, 1);
    @(negedge Clk);
    chk("t1_done_pulse", seq_done, 0);
    chk("t1_idle", busy, 0);

    // 2: four rounds, key chaining and LFSR
    r0 = rst_cyc;
    do_start(5'd4, K, 12'h5A3);
    for (int r = 0; r < 4; r++) begin
      wait_run("t2_run_to");
      chk("t2_init", gen_init_key, K + 80'(r));
      chk("t2_seed", gen_seed, seeds[r]);
      wait_valid("t2_valid_to");
      chk("t2_data", key_data, K + 80'(r + 1));
      chk("t2_index", key_index, 80'(r));
    end
    wait_done("t2_done_to");
    chk("t2_rst_cycles", 80'(rst_cyc - r0), 4);

    // 3: consumer stalls 20 cycles
    @(negedge Clk);
    key_ready = 1'b0;
    do_start(5'd2, K2, 12'h123);
    wait_valid("t3_valid_to");
    held = key_data;
    chk("t3_data", held, K2 + 80'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      chk("t3_hold_valid", key_valid, 1);
      chk("t3_hold_data", key_data, held);
      chk("t3_hold_run", gen_run, 0);
    end
    key_ready = 1'b1;
    @(negedge Clk);
    chk("t3_adv_valid", key_valid, 0);
    chk("t3_adv_reset", gen_reset, 1);
    wait_valid("t3_valid2_to");
    chk("t3_index2", key_index, 1);
    wait_done("t3_done_to");

    // 5: abort together with key_ready in round 2 of 4
    @(negedge Clk);
    do_start(5'd4, K, 12'h5A3);
    wait_valid("t5_valid0_to");
    @(negedge Clk);
    key_ready = 1'b0;
    wait_valid("t5_valid1_to");
    chk("t5_index", key_index, 1);
    abort = 1'b1; key_ready = 1'b1;
    d0 = done_cnt;
    @(negedge Clk);
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_valid", key_valid, 0);
    chk("t5_init", gen_init_key, K + 80'd1);
    chk("t5_seed", gen_seed, 12'hB46);
    chk("t5_tmo", timeout_err, 0);
    repeat (3) @(negedge Clk);
    chk("t5_no_done", 80'(done_cnt - d0), 0);
    do_start(5'd0, K, 12'h5A3);
    chk("t5_zero_busy", busy, 0);
    @(negedge Clk);
    chk("t5_zero_busy2", busy, 0);

    // 6: zero seed substitution, async reset in RUN
    do_start(5'd1, K, 12'h000);
    wait_run("t6_run_to");
    chk("t6_seed", gen_seed, 12'hACE);
    repeat (3) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("t6_reset", gen_reset, 1);
    chk("t6_run", gen_run, 0);
    chk("t6_busy", busy, 0);
    chk("t6_seed0", gen_seed, 0);
    chk("t6_init0", gen_init_key, 0);
    chk("t6_valid", key_valid, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // 4: generator hangs -> timeout
    m_hang = 1'b1;
    do_start(5'd1, K, 12'h5A3);
    runs = 0; t = 0;
    while (timeout_err !== 1'b1 && t < 5000) begin
      if (gen_run) runs++;
      @(negedge Clk);
      t++;
    end
    chk("t4_tmo", timeout_err, 1);
    chk("t4_run_cycles", 80'(runs), 4095);
    chk("t4_busy", busy, 0);
    chk("t4_reset", gen_reset, 1);
    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0;
    chk("t4_abort_sticky", timeout_err, 1);
    m_hang = 1'b0;
    do_start(5'd1, K, 12'h5A3);
    chk("t4_clear", timeout_err, 0);
    wait_done("t4_done_to");

    @(negedge Clk);
    chk("excl_run_reset", 80'(both_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
